// File: rtl/vga_board_renderer.sv
// GRID_N x GRID_N board renderer: cell decode, sprite ROM addressing, cursor/win overlays, delayed syncs.
// Optional feature macro: CURSOR_BLINK_EN (cursor border blinks every BLINK_FRAMES frames when defined).
module vga_board_renderer #(
    parameter int GRID_N       = 3,
    parameter int CELL_W       = 213,
    parameter int CELL_H       = 160,
    parameter int LINE_W       = 3,
    parameter int ROM_LAT      = 1,
    parameter int ADDR_W       = 17,
    parameter int BLINK_FRAMES = 30,
    localparam int CELLS       = GRID_N * GRID_N,
    localparam int IDX_W       = $clog2(CELLS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    input  logic                 en,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 frame_start,
    input  logic [2*CELLS-1:0]   board,
    input  logic [IDX_W-1:0]     cursor_idx,
    input  logic [CELLS-1:0]     win_mask,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [11:0]          rom_data,
    output logic [3:0]           red,
    output logic [3:0]           green,
    output logic [3:0]           blue,
    output logic                 hsync_out,
    output logic                 vsync_out
);

    typedef struct packed {
        logic en;
        logic hs;
        logic vs;
        logic border;
        logic occ;
        logic cur;
        logic win;
    } side_t;

    logic [2*CELLS-1:0] board_sh_q, board_sh_d;
    logic [IDX_W-1:0]   cursor_sh_q, cursor_sh_d;
    logic [CELLS-1:0]   win_sh_q, win_sh_d;

    logic [IDX_W-1:0]   cell_x, cell_y, idx;
    logic [9:0]         rel_x, rel_y;
    logic               on_board, is_o;
    logic [1:0]         piece;

    logic [ADDR_W-1:0]  rom_addr_p0_q, rom_addr_p0_d;
    side_t              side_q [ROM_LAT+1];
    side_t              side_d [ROM_LAT+1];
    side_t              side_out;

    logic [11:0]        rgb_q, rgb_d;
    logic               hs_q, hs_d, vs_q, vs_d;
    logic               blink_on;

    // Frame-synchronous shadows keep the picture stable within a frame.
    always_comb begin
        board_sh_d  = frame_start ? board      : board_sh_q;
        cursor_sh_d = frame_start ? cursor_idx : cursor_sh_q;
        win_sh_d    = frame_start ? win_mask   : win_sh_q;
    end

    // Stage 0: coordinate decode by compare chain, ROM address and overlay flags.
    always_comb begin
        cell_x = '0;
        rel_x  = x;
        cell_y = '0;
        rel_y  = y;
        for (int i = 1; i < GRID_N; i++) begin
            if (32'(x) >= 32'(i * CELL_W)) begin
                cell_x = IDX_W'(i);
                rel_x  = x - 10'(i * CELL_W);
            end
            if (32'(y) >= 32'(i * CELL_H)) begin
                cell_y = IDX_W'(i);
                rel_y  = y - 10'(i * CELL_H);
            end
        end
        on_board = (32'(x) < 32'(GRID_N * CELL_W)) && (32'(y) < 32'(GRID_N * CELL_H));
        idx      = IDX_W'(32'(cell_y) * 32'(GRID_N) + 32'(cell_x));
        piece    = board_sh_q[2*idx +: 2];
        is_o     = (piece == 2'b10);

        rom_addr_p0_d = ADDR_W'(32'(rel_y) * 32'(CELL_W) + 32'(rel_x)
                               + (is_o ? 32'(CELL_W * CELL_H) : 32'd0));

        side_d[0].en     = en && on_board;
        side_d[0].hs     = hsync_in;
        side_d[0].vs     = vsync_in;
        side_d[0].border = (32'(rel_x) < 32'(LINE_W)) || (32'(rel_x) >= 32'(CELL_W - LINE_W))
                        || (32'(rel_y) < 32'(LINE_W)) || (32'(rel_y) >= 32'(CELL_H - LINE_W));
        side_d[0].occ    = (piece == 2'b01) || (piece == 2'b10);
        side_d[0].cur    = (32'(cursor_sh_q) < 32'(CELLS)) && (cursor_sh_q == idx);
        side_d[0].win    = win_sh_q[idx];
        for (int i = 1; i <= ROM_LAT; i++) begin
            side_d[i] = side_q[i-1];
        end
    end

    assign side_out = side_q[ROM_LAT];

    // Output stage: flags aligned with rom_data, colour priority resolved here.
    always_comb begin
        rgb_d = 12'h000;
        hs_d  = side_out.hs;
        vs_d  = side_out.vs;
        if (!side_out.en) begin
            rgb_d = 12'h000;
        end else if (side_out.occ && (rom_data != 12'h000)) begin
            rgb_d = rom_data;
        end else if (side_out.border && side_out.cur && blink_on) begin
            rgb_d = 12'hF00;
        end else if (side_out.border) begin
            rgb_d = 12'h000;
        end else if (side_out.win) begin
            rgb_d = 12'hFF0;
        end else begin
            rgb_d = 12'hFFF;
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;

    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (frame_start) begin
            if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                cnt_d   = '0;
                blink_d = ~blink_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            blink_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    assign blink_on = blink_q;
`else
    assign blink_on = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            board_sh_q    <= '0;
            cursor_sh_q   <= '0;
            win_sh_q      <= '0;
            rom_addr_p0_q <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                side_q[i] <= '0;
            end
            rgb_q <= '0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            board_sh_q    <= board_sh_d;
            cursor_sh_q   <= cursor_sh_d;
            win_sh_q      <= win_sh_d;
            rom_addr_p0_q <= rom_addr_p0_d;
            for (int i = 0; i <= ROM_LAT; i++) begin
                side_q[i] <= side_d[i];
            end
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign rom_addr  = rom_addr_p0_q;
    assign red       = rgb_q[11:8];
    assign green     = rgb_q[7:4];
    assign blue      = rgb_q[3:0];
    assign hsync_out = hs_q;
    assign vsync_out = vs_q;

endmodule

// File: tb/tb_vga_board_renderer.sv
// Scoreboard bench for vga_board_renderer with default parameters and a 1-cycle sprite ROM model.
module tb_vga_board_renderer;

    localparam int CELLS = 9;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        en, hsync_in, vsync_in, frame_start;
    logic [17:0] board;
    logic [3:0]  cursor_idx;
    logic [8:0]  win_mask;
    logic [16:0] rom_addr;
    logic [11:0] rom_data;
    logic [3:0]  red, green, blue;
    logic        hsync_out, vsync_out;

    vga_board_renderer dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .en(en),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
        .board(board), .cursor_idx(cursor_idx), .win_mask(win_mask),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .red(red), .green(green), .blue(blue),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_fn(input logic [16:0] a);
        int v;
        v = int'(a);
        if (v % 11 == 0) return 12'h000;
        return 12'((v % 4000) + 1);
    endfunction

    always_ff @(posedge clk) rom_data <= rom_fn(rom_addr);

    int          total = 0;
    int          bad = 0;
    logic [13:0] expq[$];
    logic [17:0] sh_board;
    logic [3:0]  sh_cur;
    logic [8:0]  sh_win;
    logic        m_blink;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_addr(input int px, input int py);
        int cx, cy, idx, a;
        cx  = px / 213;
        cy  = py / 160;
        idx = cy * 3 + cx;
        a   = (py % 160) * 213 + (px % 213);
        if (sh_board[2*idx +: 2] == 2'b10) a += 213 * 160;
        return a;
    endfunction

    function automatic logic [11:0] model_rgb(input int px, input int py, input logic pen);
        int cx, cy, rx, ry, idx;
        logic [1:0]  pc;
        logic [11:0] rw;
        logic        brd, cur, blk;
        if (!pen || px >= 639 || py >= 480) return 12'h000;
        cx  = px / 213;  rx = px % 213;
        cy  = py / 160;  ry = py % 160;
        idx = cy * 3 + cx;
        pc  = sh_board[2*idx +: 2];
        rw  = rom_fn(17'(model_addr(px, py)));
        brd = (rx < 3) || (rx >= 210) || (ry < 3) || (ry >= 157);
        cur = (int'(sh_cur) == idx);
`ifdef CURSOR_BLINK_EN
        blk = m_blink;
`else
        blk = 1'b1;
`endif
        if ((pc == 2'b01 || pc == 2'b10) && rw != 12'h000) return rw;
        if (brd && cur && blk) return 12'hF00;
        if (brd) return 12'h000;
        if (sh_win[idx]) return 12'hFF0;
        return 12'hFFF;
    endfunction

    task automatic step(input int px, input int py, input logic pen, input logic phs,
                        input logic pvs, input logic pfs = 1'b0);
        logic [13:0] e, p;
        logic        onb;
        int          ea;
        x = 10'(px); y = 10'(py); en = pen;
        hsync_in = phs; vsync_in = pvs; frame_start = pfs;
        e   = {model_rgb(px, py, pen), phs, pvs};
        onb = (px < 639) && (py < 480);
        ea  = onb ? model_addr(px, py) : 0;
        @(posedge clk);
        expq.push_back(e);
        #1;
        frame_start = 1'b0;
        if (onb) chk("rom_addr", 32'(rom_addr), 32'(ea));
        if (expq.size() == LAT) begin
            p = expq.pop_front();
            chk("pixel", {18'd0, red, green, blue, hsync_out, vsync_out}, {18'd0, p});
        end
    endtask

    task automatic frame();
        repeat (3) step(0, 0, 1'b0, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        sh_board = board;
        sh_cur   = cursor_idx;
        sh_win   = win_mask;
        if (m_cnt == 29) begin
            m_cnt   = 0;
            m_blink = ~m_blink;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_rgb_async", {20'd0, red, green, blue}, 32'd0);
        chk("rst_addr_async", 32'(rom_addr), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_out", {27'd0, red, green, blue, hsync_out, vsync_out, 1'b0} , 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        expq.delete();
        expq.push_back(14'd0);
        expq.push_back(14'd0);
        sh_board = '0; sh_cur = '0; sh_win = '0;
        m_blink  = 1'b1; m_cnt = 0;
    endtask

    initial begin
        reset = 1'b1;
        x = '0; y = '0; en = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; frame_start = 1'b0;
        board = '0; cursor_idx = 4'd15; win_mask = '0;
        @(negedge clk);
        do_reset();
        repeat (4) step(20, 20, 1'b1, 1'b1, 1'b0);

        board = 18'b01;
        frame();
        step(100, 80, 1'b1, 1'b0, 1'b0);
        step(98, 80, 1'b1, 1'b1, 1'b0);

        board[9:8] = 2'b10;
        frame();
        step(313, 240, 1'b1, 1'b0, 1'b1);
        step(526, 80, 1'b1, 1'b1, 1'b1);
        step(100, 80, 1'b1, 1'b0, 1'b0);

        win_mask = 9'b001_010_100;
        frame();
        step(500, 10, 1'b1, 1'b0, 1'b0);
        board[5:4] = 2'b01;
        win_mask   = '0;
        step(500, 10, 1'b1, 1'b1, 1'b0);
        step(500, 10, 1'b1, 1'b0, 1'b1);
        frame();
        step(500, 10, 1'b1, 1'b0, 1'b0);

        board[9:8] = 2'b00;
        cursor_idx = 4'd4;
        for (int f = 0; f < 62; f++) begin
            frame();
            step(213, 200, 1'b1, 1'b0, 1'b0);
            step(300, 200, 1'b1, 1'b1, 1'b0);
        end

        step(639, 479, 1'b1, 1'b1, 1'b1);
        step(650, 100, 1'b1, 1'b0, 1'b1);
        step(10, 500, 1'b1, 1'b1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            board      = 18'($urandom);
            cursor_idx = 4'($urandom_range(0, 15));
            win_mask   = 9'($urandom);
            frame();
            for (int k = 0; k < 40; k++) begin
                step(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                     1'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        repeat (3) step(100, 100, 1'b1, 1'b1, 1'b1);
        do_reset();
        repeat (5) step(400, 300, 1'b1, 1'b1, 1'b0);
        repeat (LAT) step(0, 0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
